// File: rtl/jk_ms_reg_bank.sv
// jk_ms_reg_bank: a bank of WIDTH independent master-slave storage cells.
// The master computes its next state at every rising edge from the selected
// interpretation (JK, D, T or SR) of j/k. The slave copies the master's
// previous value on the same edge, so q always trails m_q by one cycle.
// A sticky flag records any S=R=1 input seen while the bank is in SR mode.
module jk_ms_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             err_clr,
  output logic [WIDTH-1:0] m_q,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sr_err
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] master_q;
  logic [WIDTH-1:0] master_d;
  logic [WIDTH-1:0] slave_q;
  logic             sr_err_q;
  logic             sr_err_d;
  logic             sr_illegal;

  assign mode_s = mode_e'(mode);

  // Any bit with S=R=1 while SR mode is actually updating the master.
  assign sr_illegal = en && !clr && (mode_s == MODE_SR) && (|(j & k));

  // Master next state: clear beats enable; each mode is a per-bit equation
  // whose feedback is the master's own value, never the slave's.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    master_d = master_q;
    if (clr) begin
      master_d = RESET_VAL;
    end else if (en) begin
      unique case (mode_s)
        MODE_JK: master_d = (j & ~master_q) | (~k & master_q);
        MODE_D:  master_d = j;
        MODE_T:  master_d = master_q ^ j;
        MODE_SR: master_d = (j & ~k) | (master_q & ~(k & ~j));
        default: master_d = master_q;
      endcase
    end
  end

  // Sticky error next state: a new illegal input wins over err_clr.
  always_comb begin
    sr_err_d = sr_err_q;
    if (sr_illegal) begin
      sr_err_d = 1'b1;
    end else if (err_clr) begin
      sr_err_d = 1'b0;
    end
  end

  // Master stage and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      master_q <= RESET_VAL;
      sr_err_q <= 1'b0;
    end else begin
      master_q <= master_d;
      sr_err_q <= sr_err_d;
    end
  end

  // Slave stage: unconditionally copies the master's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slave_q <= RESET_VAL;
    end else begin
      slave_q <= master_q;
    end
  end

  assign m_q    = master_q;
  assign q      = slave_q;
  assign q_bar  = ~slave_q;
  assign sr_err = sr_err_q;

endmodule

// File: tb/tb_jk_ms_reg_bank.sv
// Testbench for jk_ms_reg_bank with WIDTH=4, RESET_VAL=0.
// Directed scenarios check fixed expected values; a randomized phase checks
// every output each cycle against a table-driven behavioural model.
module tb_jk_ms_reg_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] m_q;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         sr_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  logic [W-1:0] mdl_m = '0;
  logic [W-1:0] mdl_q = '0;
  logic         mdl_err = 1'b0;

  jk_ms_reg_bank #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .j(j), .k(k), .err_clr(err_clr),
    .m_q(m_q), .q(q), .q_bar(q_bar), .sr_err(sr_err)
  );

  always #5 clk = ~clk;

  // Apply one rising edge to the model using the inputs presented at it.
  task automatic model_edge();
    logic [W-1:0] nm;
    logic         illegal;
    nm = mdl_m;
    illegal = 1'b0;
    if (clr) begin
      nm = '0;
    end else if (en) begin
      for (int i = 0; i < W; i++) begin
        int jk;
        jk = 2 * int'(j[i]) + int'(k[i]);
        case (mode)
          2'b00: begin
            if (jk == 1) nm[i] = 1'b0;
            else if (jk == 2) nm[i] = 1'b1;
            else if (jk == 3) nm[i] = !mdl_m[i];
          end
          2'b01: nm[i] = j[i];
          2'b10: if (j[i]) nm[i] = !mdl_m[i];
          default: begin
            if (jk == 1) nm[i] = 1'b0;
            else if (jk == 2) nm[i] = 1'b1;
            else if (jk == 3) illegal = 1'b1;
          end
        endcase
      end
    end
    mdl_q = mdl_m;
    mdl_m = nm;
    if (illegal) mdl_err = 1'b1;
    else if (err_clr) mdl_err = 1'b0;
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 ns.
  task automatic step(input logic en_v, input logic clr_v, input logic [1:0] mode_v,
                      input logic [W-1:0] j_v, input logic [W-1:0] k_v,
                      input logic eclr_v);
    en = en_v; clr = clr_v; mode = mode_v; j = j_v; k = k_v; err_clr = eclr_v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    mdl_m = '0;
    mdl_q = '0;
    mdl_err = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (m_q !== 4'b0000) $display("FAIL reset_m_q got=%b exp=0000", m_q); else n_pass++;
    n_checks++;
    if (q !== 4'b0000) $display("FAIL reset_q got=%b exp=0000", q); else n_pass++;
    n_checks++;
    if (q_bar !== 4'b1111) $display("FAIL reset_q_bar got=%b exp=1111", q_bar); else n_pass++;
    n_checks++;
    if (sr_err !== 1'b0) $display("FAIL reset_sr_err got=%b exp=0", sr_err); else n_pass++;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_jk_basic();
    step(1'b1, 1'b0, 2'b00, 4'b1010, 4'b0101, 1'b0);
    n_checks++;
    if (m_q !== 4'b1010) $display("FAIL jk_basic_m1 got=%b exp=1010", m_q); else n_pass++;
    n_checks++;
    if (q !== 4'b0000) $display("FAIL jk_basic_q1 got=%b exp=0000", q); else n_pass++;
    step(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
    n_checks++;
    if (q !== 4'b1010) $display("FAIL jk_basic_q2 got=%b exp=1010", q); else n_pass++;
    n_checks++;
    if (q_bar !== 4'b0101) $display("FAIL jk_basic_qbar2 got=%b exp=0101", q_bar); else n_pass++;
    n_checks++;
    if (m_q !== 4'b1010) $display("FAIL jk_basic_hold got=%b exp=1010", m_q); else n_pass++;
  endtask

  task automatic test_jk_toggle();
    logic [W-1:0] exp_m [3];
    logic [W-1:0] exp_q [3];
    exp_m[0] = 4'b0101; exp_m[1] = 4'b1010; exp_m[2] = 4'b0101;
    exp_q[0] = 4'b1010; exp_q[1] = 4'b0101; exp_q[2] = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b0, 2'b00, 4'b1111, 4'b1111, 1'b0);
      n_checks++;
      if (m_q !== exp_m[n]) $display("FAIL jk_toggle_m[%0d] got=%b exp=%b", n, m_q, exp_m[n]);
      else n_pass++;
      n_checks++;
      if (q !== exp_q[n]) $display("FAIL jk_toggle_q[%0d] got=%b exp=%b", n, q, exp_q[n]);
      else n_pass++;
    end
  endtask

  task automatic test_t_and_hold();
    step(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0);
    n_checks++;
    if (m_q !== 4'b0000) $display("FAIL t_pre_clr got=%b exp=0000", m_q); else n_pass++;
    step(1'b1, 1'b0, 2'b10, 4'b0011, 4'b1111, 1'b0);
    n_checks++;
    if (m_q !== 4'b0011) $display("FAIL t_m1 got=%b exp=0011", m_q); else n_pass++;
    step(1'b1, 1'b0, 2'b10, 4'b0011, 4'b0000, 1'b0);
    n_checks++;
    if (m_q !== 4'b0000) $display("FAIL t_m2 got=%b exp=0000", m_q); else n_pass++;
    n_checks++;
    if (q !== 4'b0011) $display("FAIL t_q2 got=%b exp=0011", q); else n_pass++;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 2'b10, 4'b1111, 4'b1111, 1'b0);
      n_checks++;
      if (m_q !== 4'b0000) $display("FAIL t_hold_m[%0d] got=%b exp=0000", n, m_q); else n_pass++;
      n_checks++;
      if (q !== 4'b0000) $display("FAIL t_hold_q[%0d] got=%b exp=0000", n, q); else n_pass++;
    end
  endtask

  task automatic test_sr_err();
    // m_q is 0000 here.
    step(1'b1, 1'b0, 2'b11, 4'b1100, 4'b0100, 1'b0);
    n_checks++;
    if (m_q !== 4'b1000) $display("FAIL sr_m got=%b exp=1000", m_q); else n_pass++;
    n_checks++;
    if (sr_err !== 1'b1) $display("FAIL sr_err_set got=%b exp=1", sr_err); else n_pass++;
    step(1'b1, 1'b0, 2'b11, 4'b1100, 4'b0100, 1'b1);
    n_checks++;
    if (sr_err !== 1'b1) $display("FAIL sr_err_set_wins got=%b exp=1", sr_err); else n_pass++;
    step(1'b1, 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b1);
    n_checks++;
    if (sr_err !== 1'b0) $display("FAIL sr_err_clr got=%b exp=0", sr_err); else n_pass++;
    n_checks++;
    if (m_q !== 4'b1000) $display("FAIL sr_hold got=%b exp=1000", m_q); else n_pass++;
    step(1'b1, 1'b1, 2'b11, 4'b1111, 4'b1111, 1'b0);
    n_checks++;
    if (sr_err !== 1'b0) $display("FAIL sr_err_clr_cycle got=%b exp=0", sr_err); else n_pass++;
    step(1'b0, 1'b0, 2'b11, 4'b1111, 4'b1111, 1'b0);
    n_checks++;
    if (sr_err !== 1'b0) $display("FAIL sr_err_en_low got=%b exp=0", sr_err); else n_pass++;
    step(1'b1, 1'b0, 2'b11, 4'b0110, 4'b1001, 1'b0);
    n_checks++;
    if (m_q !== 4'b0110) $display("FAIL sr_set_reset got=%b exp=0110", m_q); else n_pass++;
  endtask

  task automatic test_clr_and_async_reset();
    step(1'b1, 1'b0, 2'b01, 4'b1111, 4'b0000, 1'b0);
    n_checks++;
    if (m_q !== 4'b1111) $display("FAIL d_load got=%b exp=1111", m_q); else n_pass++;
    step(1'b1, 1'b1, 2'b01, 4'b0101, 4'b0000, 1'b0);
    n_checks++;
    if (m_q !== 4'b0000) $display("FAIL clr_wins got=%b exp=0000", m_q); else n_pass++;
    step(1'b0, 1'b0, 2'b01, 4'b0101, 4'b0000, 1'b0);
    n_checks++;
    if (q !== 4'b0000) $display("FAIL clr_q got=%b exp=0000", q); else n_pass++;
    step(1'b1, 1'b0, 2'b11, 4'b1000, 4'b1000, 1'b0);
    step(1'b1, 1'b0, 2'b01, 4'b0110, 4'b0000, 1'b0);
    n_checks++;
    if (m_q !== 4'b0110 || sr_err !== 1'b1)
      $display("FAIL pre_reset_state got=%b/%b exp=0110/1", m_q, sr_err);
    else n_pass++;
    step(1'b0, 1'b0, 2'b01, 4'b0000, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (m_q !== 4'b0000 || q !== 4'b0000 || sr_err !== 1'b0)
      $display("FAIL async_reset got=%b/%b/%b exp=0000/0000/0", m_q, q, sr_err);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (m_q !== 4'b0000 || q_bar !== 4'b1111)
      $display("FAIL reset_held_over_edge got=%b/%b exp=0000/1111", m_q, q_bar);
    else n_pass++;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (m_q !== mdl_m || q !== mdl_q || sr_err !== mdl_err)
          $display("FAIL rand_reset[%0d] got=%b/%b/%b exp=%b/%b/%b",
                   n, m_q, q, sr_err, mdl_m, mdl_q, mdl_err);
        else n_pass++;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 3) == 0));
      n_checks++;
      if (m_q !== mdl_m) $display("FAIL rand_m_q[%0d] got=%b exp=%b", n, m_q, mdl_m);
      else n_pass++;
      n_checks++;
      if (q !== mdl_q || q_bar !== ~mdl_q)
        $display("FAIL rand_q[%0d] got=%b/%b exp=%b/%b", n, q, q_bar, mdl_q, ~mdl_q);
      else n_pass++;
      n_checks++;
      if (sr_err !== mdl_err) $display("FAIL rand_sr_err[%0d] got=%b exp=%b", n, sr_err, mdl_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_jk_basic();
    test_jk_toggle();
    test_t_and_hold();
    test_sr_err();
    test_clr_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_ms_reg_bank.md
Name: jk_ms_reg_bank

Overview:
- Parametrised bank of WIDTH master-slave JK storage cells on a single clock.
- Each cell has a master stage that computes its next state at posedge clk, and a slave stage that copies the master one cycle later.
- A runtime mode selects JK, D, T or SR interpretation of the j/k inputs; illegal SR input is flagged by a sticky error.
- Used as a general flag/state register wherever edge-separated master/slave timing is required.

Parameters:
- WIDTH, 8, number of independent cells (1..64).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into master and slave on reset or clear.

Ports:
- clk      input   1      single clock; all state updates on rising edge.
- rst_n    input   1      asynchronous, active-low reset.
- en       input   1      master update enable.
- clr      input   1      synchronous clear of master to RESET_VAL.
- mode     input   2      00=JK, 01=D, 10=T, 11=SR.
- j        input   WIDTH  J / D / T / S per bit, by mode.
- k        input   WIDTH  K / unused / unused / R per bit, by mode.
- err_clr  input   1      clears sr_err.
- m_q      output  WIDTH  master stage value (observation only).
- q        output  WIDTH  slave stage value, the bank output.
- q_bar    output  WIDTH  combinational ~q.
- sr_err   output  1      sticky illegal-SR flag.

Behaviour:
- Reset: rst_n low asynchronously forces m_q=RESET_VAL, q=RESET_VAL, sr_err=0. This holds regardless of clk, including mid-operation; rst_n deassertion is sampled at the next posedge.
- Slave: every posedge, q <= m_q (previous value), independent of en, clr and mode. q is therefore always exactly one cycle behind m_q.
- Master priority per posedge: clr=1 -> m_q <= RESET_VAL; else en=0 -> hold; else per-bit next state below.
- Per-bit next state when en=1, clr=0 (m = current m_q bit):
  - JK: 00 hold, 01 ->0, 10 ->1, 11 ->~m.
  - D: m <= j; k ignored.
  - T: j=1 -> ~m, j=0 -> hold; k ignored.
  - SR: 00 hold, 01 ->0, 10 ->1, 11 -> hold (illegal).
- Feedback uses the master's own value, not q. With JK=11 held, m_q toggles every cycle and q shows the same sequence one cycle later.
- Latency: j/k sampled at edge N appear on m_q after edge N and on q after edge N+1.
- sr_err:
  - Set condition: at a posedge with mode=11, en=1, clr=0 and any bit having j&k=1.
  - Set wins over err_clr in the same cycle.
  - Otherwise err_clr=1 clears it; otherwise it holds.
  - A clr cycle never sets it.
- Mode changes take effect on the same edge they are sampled; there is no pipeline flush.
- q_bar is purely combinational from q and is valid during reset (~RESET_VAL).
- All bits are independent; there is no cross-bit interaction except the OR-reduction feeding sr_err.

Test Plan:
- WIDTH=4, RESET_VAL=0. Pulse rst_n low between edges, then release; drive en=1, mode=00, j=4'b1010, k=4'b0101 at edge 1 -> after edge 1 m_q=1010, q=0000; after edge 2 q=1010, q_bar=0101.
- Hold mode=00, j=k=4'b1111, en=1 from m_q=1010 -> m_q sequence 0101, 1010, 0101; q shows the same sequence one edge later.
- mode=10, j=4'b0011, en=1 for 2 edges from m_q=0000 -> m_q=0011 then 0000. Then en=0 for 3 edges -> m_q stays 0000 and q settles to 0000 after one edge.
- mode=11, j=4'b1100, k=4'b0100 -> bit2 holds, bit3 set, sr_err=1 after the edge. Assert err_clr with an illegal input still present -> sr_err stays 1. Remove the illegal input, keep err_clr -> sr_err=0.
- m_q=1111 with clr=1, en=1, mode=01, j=0101 -> m_q=0000 (clr wins) and q=0000 one edge later. Then assert rst_n low asynchronously between edges while m_q=0110 -> m_q=q=0000 and sr_err=0 immediately, without waiting for a clock edge.
